addr_delta_feeder: RTL and testbench

ADDR_DELTA_FEEDER -- requirements
Module: addr_delta_feeder

---
 rtl/cache_sim_pkg.sv | 18 +
 rtl/addr_fifo.sv | 64 ++++++
 rtl/addr_delta_feeder.sv | 127 ++++++++++++
 tb/tb_addr_delta_feeder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_sim_pkg.sv
// Shared definitions for the cache-simulation address path: feeder state
// encoding, default address width and a small state classification helper.
package cache_sim_pkg;

    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } feed_state_e;

    // True for the states in which new delta beats may be taken.
    function automatic logic accepting_state(input feed_state_e s);
        return (s == ST_IDLE) || (s == ST_STREAM);
    endfunction

endpackage

// File: rtl/addr_fifo.sv
// Synchronous FIFO holding absolute addresses; power-of-two depth so the
// pointers wrap naturally, with level/full/empty status.
module addr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (level_r == LVL_W'(DEPTH));
    assign empty  = (level_r == LVL_W'(0));
    assign level  = level_r;
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    // Drive zero rather than a stale slot when nothing is buffered.
    assign head   = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/addr_delta_feeder.sv
// Turns a stream of signed address deltas into absolute addresses and
// buffers them for the cache, signalling when each trace has fully drained.
module addr_delta_feeder
    import cache_sim_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         delta_valid,
    input  logic [ADDR_W-1:0]            delta_in,
    input  logic                         delta_last,
    output logic                         delta_ready,
    output logic [ADDR_W-1:0]            addr,
    output logic                         addr_valid,
    input  logic                         addr_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [31:0]                  issued_count,
    output logic                         trace_done
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    feed_state_e       state_r;
    feed_state_e       state_next_s;
    logic [ADDR_W-1:0] acc_r;
    logic [ADDR_W-1:0] acc_next_s;
    logic              ready_r;
    logic              ready_next_s;
    logic [31:0]       issued_r;
    logic              done_r;
    logic              done_next_s;
    logic [LVL_W-1:0]  level_s;
    logic [LVL_W-1:0]  level_next_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              accept_s;
    logic              pop_s;

    assign accept_s     = delta_valid && ready_r;
    assign pop_s        = addr_valid && addr_ready;
    assign addr_valid   = !fifo_empty_s;
    assign fifo_level   = level_s;
    assign delta_ready  = ready_r;
    assign issued_count = issued_r;
    assign trace_done   = done_r;

    addr_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept_s && !fifo_full_s),
        .push_data (acc_next_s),
        .pop       (pop_s),
        .head      (addr),
        .level     (level_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Next accumulator value, next state and the registered-ready lookahead.
    always_comb begin
        acc_next_s   = (state_r == ST_IDLE) ? delta_in : acc_r + delta_in;
        state_next_s = state_r;
        done_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = delta_last ? ST_DRAIN : ST_STREAM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept_s && delta_last) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s) begin
                    state_next_s = ST_IDLE;
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        case ({accept_s, pop_s})
            2'b10:   level_next_s = level_s + LVL_W'(1);
            2'b01:   level_next_s = level_s - LVL_W'(1);
            default: level_next_s = level_s;
        endcase
        // Ready is registered, so a pop while full re-opens it one cycle later.
        ready_next_s = accepting_state(state_next_s) &&
                       (level_next_s < LVL_W'(FIFO_DEPTH));
    end

    // Control state, accumulator and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            acc_r    <= {ADDR_W{1'b0}};
            ready_r  <= 1'b0;
            issued_r <= 32'd0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                acc_r <= acc_next_s;
            end
            ready_r <= ready_next_s;
            if (pop_s) begin
                issued_r <= issued_r + 32'd1;
            end
            done_r <= done_next_s;
        end
    end

endmodule

// File: tb/tb_addr_delta_feeder.sv
// Randomized and directed bench for addr_delta_feeder against a queue-based
// model of the address stream, buffer occupancy and trace completion.
module tb_addr_delta_feeder;

    localparam int ADDR_W     = 32;
    localparam int FIFO_DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              delta_valid;
    logic [ADDR_W-1:0] delta_in;
    logic              delta_last;
    logic              delta_ready;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready;
    logic [3:0]        fifo_level;
    logic [31:0]       issued_count;
    logic              trace_done;

    addr_delta_feeder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .delta_valid  (delta_valid),
        .delta_in     (delta_in),
        .delta_last   (delta_last),
        .delta_ready  (delta_ready),
        .addr         (addr),
        .addr_valid   (addr_valid),
        .addr_ready   (addr_ready),
        .fifo_level   (fifo_level),
        .issued_count (issued_count),
        .trace_done   (trace_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model of the feeder as seen from its ports.
    logic [31:0] m_q[$];
    logic [31:0] m_acc;
    logic        m_in_trace;
    logic        m_draining;
    logic        m_ready;
    logic        m_done;
    logic [31:0] m_issued;
    logic        acc_ok;
    logic [31:0] popped_log[$];
    int          done_seen;
    logic [31:0] beat_d[$];
    logic        beat_l[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l,
                        input logic r, input logic rs);
        logic done_now;
        delta_valid = v;
        delta_in    = d;
        delta_last  = l;
        addr_ready  = r;
        rst         = rs;
        if (!rs) begin
            m_q.delete();
            m_acc      = 32'd0;
            m_in_trace = 1'b0;
            m_draining = 1'b0;
            m_ready    = 1'b0;
            m_done     = 1'b0;
            m_issued   = 32'd0;
            acc_ok     = 1'b0;
        end else begin
            done_now = m_draining && (m_q.size() == 0);
            acc_ok   = v && m_ready;
            if ((m_q.size() > 0) && r) begin
                popped_log.push_back(m_q.pop_front());
                m_issued = m_issued + 32'd1;
            end
            if (acc_ok) begin
                m_acc = m_in_trace ? m_acc + d : d;
                m_q.push_back(m_acc);
                if (l) begin
                    m_draining = 1'b1;
                    m_in_trace = 1'b0;
                end else begin
                    m_in_trace = 1'b1;
                end
            end
            if (done_now) m_draining = 1'b0;
            m_done  = done_now;
            m_ready = !m_draining && (m_q.size() < FIFO_DEPTH);
        end
        @(posedge clk);
        #1;
        check_eq("addr_valid", 32'(addr_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check_eq("addr", addr, m_q[0]);
        check_eq("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check_eq("delta_ready", 32'(delta_ready), 32'(m_ready));
        check_eq("issued_count", issued_count, m_issued);
        check_eq("trace_done", 32'(trace_done), 32'(m_done));
        if (trace_done) done_seen++;
    endtask

    // Feed the queued beats until they are all delivered and the trace retired.
    task automatic run_queue(input int vld_pct, input int rdy_pct, input int budget);
        int  n;
        logic v;
        logic r;
        n = 0;
        while (!((beat_d.size() == 0) && !m_draining && (m_q.size() == 0)) && (n < budget)) begin
            v = (beat_d.size() > 0) && ($urandom_range(99) < vld_pct);
            r = ($urandom_range(99) < rdy_pct);
            step(v, v ? beat_d[0] : $urandom, v ? beat_l[0] : 1'b0, r, 1'b1);
            if (acc_ok) begin
                void'(beat_d.pop_front());
                void'(beat_l.pop_front());
            end
            n++;
        end
        if (n >= budget) check_eq("run_timeout", 32'd1, 32'd0);
    endtask

    task automatic add_beat(input logic [31:0] d, input logic l);
        beat_d.push_back(d);
        beat_l.push_back(l);
    endtask

    initial begin
        logic [31:0] exp_a[$];
        rst = 1'b0; delta_valid = 1'b0; delta_in = 32'd0; delta_last = 1'b0; addr_ready = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1234, 1'b0, 1'b1, 1'b0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_ready", 32'(delta_ready), 32'd0);
        check_eq("rst_addr", addr, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check_eq("ready_after_rst", 32'(delta_ready), 32'd1);

        // Basic stream with signed deltas.
        popped_log.delete(); done_seen = 0;
        add_beat(32'h1000, 1'b0); add_beat(32'd32, 1'b0);
        add_beat(-32'sd16, 1'b0); add_beat(32'd64, 1'b1);
        run_queue(100, 100, 60);
        exp_a = '{32'h1000, 32'h1020, 32'h1010, 32'h1050};
        check_eq("t1_count", 32'(popped_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < popped_log.size(); i++) check_eq("t1_addr", popped_log[i], exp_a[i]);
        check_eq("t1_done", 32'(done_seen), 32'd1);
        check_eq("t1_issued", issued_count, 32'd4);

        // Address wrap at 2^32.
        popped_log.delete();
        add_beat(32'hFFFF_FFF0, 1'b0); add_beat(32'h20, 1'b1);
        run_queue(100, 100, 60);
        check_eq("wrap_count", 32'(popped_log.size()), 32'd2);
        if (popped_log.size() == 2) begin
            check_eq("wrap_a0", popped_log[0], 32'hFFFF_FFF0);
            check_eq("wrap_a1", popped_log[1], 32'h0000_0010);
        end

        // Single-beat trace.
        popped_log.delete(); done_seen = 0;
        add_beat(32'h2000, 1'b1);
        run_queue(100, 100, 60);
        check_eq("single_count", 32'(popped_log.size()), 32'd1);
        if (popped_log.size() == 1) check_eq("single_addr", popped_log[0], 32'h2000);
        check_eq("single_done", 32'(done_seen), 32'd1);
        check_eq("single_ready", 32'(delta_ready), 32'd1);

        // Fill to full with the consumer stalled, then release.
        popped_log.delete();
        add_beat(32'h100, 1'b0);
        for (int i = 1; i < 10; i++) add_beat(32'd4, (i == 9));
        for (int c = 0; c < 14; c++) begin
            step(beat_d.size() > 0, beat_d.size() > 0 ? beat_d[0] : 32'd0,
                 beat_d.size() > 0 ? beat_l[0] : 1'b0, 1'b0, 1'b1);
            if (acc_ok) begin
                void'(beat_d.pop_front());
                void'(beat_l.pop_front());
            end
        end
        check_eq("full_level", 32'(fifo_level), 32'd8);
        check_eq("full_ready", 32'(delta_ready), 32'd0);
        check_eq("full_head", addr, 32'h100);
        run_queue(100, 100, 80);
        check_eq("full_count", 32'(popped_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < popped_log.size(); i++)
            check_eq("full_order", popped_log[i], 32'h100 + 32'(4 * i));

        // Continuous flow at level 1.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i == 0) ? 32'h8000 : 32'd8, (i == 19), 1'b1, 1'b1);
            if (i >= 1) check_eq("stream_level", 32'(fifo_level), 32'd1);
        end
        run_queue(100, 100, 40);

        // Reset in the middle of a trace.
        popped_log.delete(); done_seen = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check_eq("mid_rst_valid", 32'(addr_valid), 32'd0);
        check_eq("mid_rst_level", 32'(fifo_level), 32'd0);
        check_eq("mid_rst_issued", issued_count, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        add_beat(32'h5555, 1'b1);
        run_queue(100, 100, 40);
        check_eq("mid_rst_done", 32'(done_seen), 32'd1);
        check_eq("mid_rst_base", (popped_log.size() > 0) ? popped_log[0] : 32'hDEAD, 32'h5555);

        // Randomized traces with random back-pressure on both sides.
        for (int t = 0; t < 30; t++) begin
            int nb;
            nb = $urandom_range(6, 1);
            for (int b = 0; b < nb; b++) add_beat($urandom, (b == nb - 1));
            run_queue($urandom_range(100, 30), $urandom_range(100, 20), 400);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
